// File: rtl/game_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_if
// Link between the turn sequencer (game_ctrl) and the history block.
//   guess0..3   working guess digits shown/stored by the history block
//   hist_mode   1 = history block in review mode
//   hist_up     single-cycle pulse, history btn_up
//   hist_down   single-cycle pulse, history btn_down
//   hist_select single-cycle pulse, history btn_select (commit guess)
//   hist_full   history block has no free turn slot
// master: game_ctrl side, slave: history block side.
// -----------------------------------------------------------------------------
interface game_ctrl_if;
  logic [2:0] guess0;
  logic [2:0] guess1;
  logic [2:0] guess2;
  logic [2:0] guess3;
  logic       hist_mode;
  logic       hist_up;
  logic       hist_down;
  logic       hist_select;
  logic       hist_full;

  modport master (
    output guess0, guess1, guess2, guess3,
    output hist_mode, hist_up, hist_down, hist_select,
    input  hist_full
  );

  modport slave (
    input  guess0, guess1, guess2, guess3,
    input  hist_mode, hist_up, hist_down, hist_select,
    output hist_full
  );
endinterface

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Turn sequencer for the code-breaking game. Holds the working guess and
// cursor, latches the secret code, drives the history block and scores each
// committed guess (black/white pegs) over an 8-cycle pass.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   btn_*                   debounced single-cycle button pulses
//   secret0..3, secret_valid secret code from the generator
//   hist (master)           guess digits, hist_mode/up/down/select, hist_full
//   cursor                  digit being edited
//   black, white            score of the last committed guess
//   score_valid             black/white valid (cleared on next scoring pass)
//   turn                    number of scored turns
//   busy                    high while scoring
//   won, lost               terminal status, held until reset
//   reject                  single-cycle pulse when a guess is refused
//
// Optional: define GAME_CTRL_DUP_CHECK_EN to refuse guesses containing
// repeated digits; otherwise duplicates are accepted and reject stays 0.
// -----------------------------------------------------------------------------
module game_ctrl #(
  parameter int MAX_TURNS = 8,
  parameter int TURN_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_select,
  input  logic              btn_mode,
  input  logic [2:0]        secret0,
  input  logic [2:0]        secret1,
  input  logic [2:0]        secret2,
  input  logic [2:0]        secret3,
  input  logic              secret_valid,
  game_ctrl_if.master       hist,
  output logic [1:0]        cursor,
  output logic [2:0]        black,
  output logic [2:0]        white,
  output logic              score_valid,
  output logic [TURN_W-1:0] turn,
  output logic              busy,
  output logic              won,
  output logic              lost,
  output logic              reject
);

  typedef enum logic [2:0] {IDLE, EDIT, SCORE, REVIEW, WON, LOST} state_t;

  state_t            state_q, state_d, ret_q, ret_d;
  logic [2:0]        guess_q [4];
  logic [2:0]        guess_d [4];
  logic [2:0]        secret_q [4];
  logic [2:0]        secret_d [4];
  logic [1:0]        cursor_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        acc_q, acc_d;
  logic [2:0]        black_tmp_q, black_tmp_d;
  logic [2:0]        black_d, white_d;
  logic              score_valid_d, busy_d, won_d, lost_d, reject_d;
  logic [TURN_W-1:0] turn_d, turn_inc;
  logic              mode_q, mode_d;
  logic              up_q, up_d, down_q, down_d, sel_q, sel_d;
  logic              accept_sel;
  logic [2:0]        cnt_g, cnt_s, min_gs, black_now;

  assign hist.guess0      = guess_q[0];
  assign hist.guess1      = guess_q[1];
  assign hist.guess2      = guess_q[2];
  assign hist.guess3      = guess_q[3];
  assign hist.hist_mode   = mode_q;
  assign hist.hist_up     = up_q;
  assign hist.hist_down   = down_q;
  assign hist.hist_select = sel_q;

  // Scoring helpers: exact matches, and for digit value step_q the number of
  // occurrences in guess and secret. Summing min() over all 8 digit values
  // gives black+white, so white falls out as the sum minus black.
  always_comb begin
    cnt_g     = '0;
    cnt_s     = '0;
    black_now = '0;
    for (int i = 0; i < 4; i++) begin
      if (guess_q[i] == step_q)      cnt_g     = cnt_g + 3'd1;
      if (secret_q[i] == step_q)     cnt_s     = cnt_s + 3'd1;
      if (guess_q[i] == secret_q[i]) black_now = black_now + 3'd1;
    end
    min_gs = (cnt_g < cnt_s) ? cnt_g : cnt_s;
  end

`ifdef GAME_CTRL_DUP_CHECK_EN
  assign accept_sel = !((guess_q[0] == guess_q[1]) || (guess_q[0] == guess_q[2]) ||
                        (guess_q[0] == guess_q[3]) || (guess_q[1] == guess_q[2]) ||
                        (guess_q[1] == guess_q[3]) || (guess_q[2] == guess_q[3]));
`else
  assign accept_sel = 1'b1;
`endif

  // Next-state and next-output logic; every output is the registered copy of
  // its *_d value, so pulses appear the cycle after the triggering button.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    guess_d       = guess_q;
    secret_d      = secret_q;
    cursor_d      = cursor;
    step_d        = step_q;
    acc_d         = acc_q;
    black_tmp_d   = black_tmp_q;
    black_d       = black;
    white_d       = white;
    score_valid_d = score_valid;
    turn_d        = turn;
    busy_d        = busy;
    won_d         = won;
    lost_d        = lost;
    reject_d      = 1'b0;
    mode_d        = mode_q;
    up_d          = 1'b0;
    down_d        = 1'b0;
    sel_d         = 1'b0;
    turn_inc      = turn + 1'b1;

    case (state_q)
      IDLE: begin
        if (secret_valid) begin
          secret_d[0] = secret0;
          secret_d[1] = secret1;
          secret_d[2] = secret2;
          secret_d[3] = secret3;
          state_d     = EDIT;
        end
      end

      EDIT: begin
        if (btn_select) begin
          if (accept_sel) begin
            sel_d         = 1'b1;
            state_d       = SCORE;
            busy_d        = 1'b1;
            score_valid_d = 1'b0;
            step_d        = '0;
            acc_d         = '0;
          end else begin
            reject_d = 1'b1;
          end
        end else if (btn_mode) begin
          state_d = REVIEW;
          ret_d   = EDIT;
          mode_d  = 1'b1;
        end else if (btn_up) begin
          guess_d[cursor] = guess_q[cursor] + 3'd1;
        end else if (btn_down) begin
          guess_d[cursor] = guess_q[cursor] - 3'd1;
        end else if (btn_left) begin
          cursor_d = cursor - 2'd1;
        end else if (btn_right) begin
          cursor_d = cursor + 2'd1;
        end
      end

      SCORE: begin
        acc_d  = acc_q + min_gs;
        step_d = step_q + 3'd1;
        if (step_q == 3'd0) black_tmp_d = black_now;
        if (step_q == 3'd7) begin
          black_d       = black_tmp_q;
          white_d       = acc_q + min_gs - black_tmp_q;
          score_valid_d = 1'b1;
          turn_d        = turn_inc;
          busy_d        = 1'b0;
          if (black_tmp_q == 3'd4) begin
            state_d = WON;
            won_d   = 1'b1;
          end else if ((turn_inc == TURN_W'(MAX_TURNS)) || hist.hist_full) begin
            state_d = LOST;
            lost_d  = 1'b1;
          end else begin
            state_d = EDIT;
          end
        end
      end

      REVIEW: begin
        if (btn_mode) begin
          state_d = ret_q;
          mode_d  = 1'b0;
        end else if (btn_up) begin
          up_d = 1'b1;
        end else if (btn_down) begin
          down_d = 1'b1;
        end
      end

      WON, LOST: begin
        if (btn_mode) begin
          state_d = REVIEW;
          ret_d   = state_q;
          mode_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including any
  // hist_select that would otherwise be pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_q       <= EDIT;
      guess_q     <= '{default: 3'd0};
      secret_q    <= '{default: 3'd0};
      cursor      <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      black_tmp_q <= '0;
      black       <= '0;
      white       <= '0;
      score_valid <= 1'b0;
      turn        <= '0;
      busy        <= 1'b0;
      won         <= 1'b0;
      lost        <= 1'b0;
      reject      <= 1'b0;
      mode_q      <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      guess_q     <= guess_d;
      secret_q    <= secret_d;
      cursor      <= cursor_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      black_tmp_q <= black_tmp_d;
      black       <= black_d;
      white       <= white_d;
      score_valid <= score_valid_d;
      turn        <= turn_d;
      busy        <= busy_d;
      won         <= won_d;
      lost        <= lost_d;
      reject      <= reject_d;
      mode_q      <= mode_d;
      up_q        <= up_d;
      down_q      <= down_d;
      sel_q       <= sel_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
// Self-checking bench for game_ctrl. Expected scores are pushed to a
// scoreboard queue when a guess is submitted and popped when the DUT raises
// score_valid. Guess/cursor/turn are tracked by a small reference model.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

  localparam int MAX_TURNS = 8;
  localparam int TURN_W    = 4;

  localparam logic [5:0] BL = 6'b000001;
  localparam logic [5:0] BR = 6'b000010;
  localparam logic [5:0] BU = 6'b000100;
  localparam logic [5:0] BD = 6'b001000;
  localparam logic [5:0] BS = 6'b010000;
  localparam logic [5:0] BM = 6'b100000;

  typedef struct {
    logic [2:0] b;
    logic [2:0] w;
    int         t;
    logic       won;
    logic       lost;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
  logic              btn_down = 1'b0, btn_select = 1'b0, btn_mode = 1'b0;
  logic [2:0]        secret0 = '0, secret1 = '0, secret2 = '0, secret3 = '0;
  logic              secret_valid = 1'b0;
  logic [1:0]        cursor;
  logic [2:0]        black, white;
  logic              score_valid, busy, won, lost, reject;
  logic [TURN_W-1:0] turn;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   mg[4];
  int   msec[4];
  int   mcur;
  int   mturn;

  game_ctrl_if gif ();

  game_ctrl #(.MAX_TURNS(MAX_TURNS), .TURN_W(TURN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_select  (btn_select),
    .btn_mode    (btn_mode),
    .secret0     (secret0),
    .secret1     (secret1),
    .secret2     (secret2),
    .secret3     (secret3),
    .secret_valid(secret_valid),
    .hist        (gif.master),
    .cursor      (cursor),
    .black       (black),
    .white       (white),
    .score_valid (score_valid),
    .turn        (turn),
    .busy        (busy),
    .won         (won),
    .lost        (lost),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a set of buttons for exactly one sampling edge; returns #1 after it.
  task automatic applyStimulus(input logic [5:0] b);
    {btn_mode, btn_select, btn_down, btn_up, btn_right, btn_left} = b;
    @(posedge clk); #1;
    {btn_mode, btn_select, btn_down, btn_up, btn_right, btn_left} = '0;
  endtask

  function automatic logic [2:0] guessOut(input int i);
    case (i)
      0: return gif.guess0;
      1: return gif.guess1;
      2: return gif.guess2;
      default: return gif.guess3;
    endcase
  endfunction

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) mg[i] = 0;
    mcur  = 0;
    mturn = 0;
  endtask

  task automatic loadSecret(input int a, input int b, input int c, input int d);
    secret0 = 3'(a); secret1 = 3'(b); secret2 = 3'(c); secret3 = 3'(d);
    msec[0] = a; msec[1] = b; msec[2] = c; msec[3] = d;
    secret_valid = 1'b1;
    @(posedge clk); #1;
    secret_valid = 1'b0;
  endtask

  task automatic setGuess(input int a, input int b, input int c, input int d);
    int tgt[4];
    tgt[0] = a; tgt[1] = b; tgt[2] = c; tgt[3] = d;
    for (int i = 0; i < 4; i++) begin
      while (mcur != i) begin
        applyStimulus(BR);
        mcur = (mcur + 1) % 4;
      end
      while (mg[i] != tgt[i]) begin
        applyStimulus(BU);
        mg[i] = (mg[i] + 1) % 8;
      end
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("guess%0d", i), 32'(guessOut(i)), 32'(mg[i]));
  endtask

  function automatic void scoreRef(output int bc, output int wc);
    int tot;
    bc  = 0;
    tot = 0;
    for (int i = 0; i < 4; i++) if (mg[i] == msec[i]) bc++;
    for (int v = 0; v < 8; v++) begin
      int ng, ns;
      ng = 0; ns = 0;
      for (int i = 0; i < 4; i++) begin
        if (mg[i] == v)   ng++;
        if (msec[i] == v) ns++;
      end
      tot += (ng < ns) ? ng : ns;
    end
    wc = tot - bc;
  endfunction

  task automatic submitGuess(input logic hfull);
    exp_t e;
    int   bc, wc, busyCnt, selCnt;
    logic got;
    scoreRef(bc, wc);
    mturn++;
    e.b    = 3'(bc);
    e.w    = 3'(wc);
    e.t    = mturn;
    e.won  = (bc == 4);
    e.lost = !e.won && ((mturn == MAX_TURNS) || hfull);
    sbq.push_back(e);
    gif.hist_full = hfull;
    applyStimulus(BS);
    checkOutput("hist_select_first", 32'(gif.hist_select), 32'd1);
    busyCnt = 0; selCnt = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (busy) busyCnt++;
      if (gif.hist_select) selCnt++;
      if (score_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("score_arrived", 32'(got), 32'd1);
    checkOutput("busy_cycles", 32'(busyCnt), 32'd8);
    checkOutput("hist_select_cycles", 32'(selCnt), 32'd1);
    e = sbq.pop_front();
    checkOutput("black", 32'(black), 32'(e.b));
    checkOutput("white", 32'(white), 32'(e.w));
    checkOutput("turn", 32'(turn), 32'(e.t));
    checkOutput("won", 32'(won), 32'(e.won));
    checkOutput("lost", 32'(lost), 32'(e.lost));
    gif.hist_full = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_guess", {20'd0, gif.guess0, gif.guess1, gif.guess2, gif.guess3}, 32'd0);
    checkOutput("rst_cursor", 32'(cursor), 32'd0);
    checkOutput("rst_hist", {28'd0, gif.hist_mode, gif.hist_up, gif.hist_down, gif.hist_select}, 32'd0);
    checkOutput("rst_score", {26'd0, black, white}, 32'd0);
    checkOutput("rst_flags", {27'd0, score_valid, busy, won, lost, reject}, 32'd0);
    checkOutput("rst_turn", 32'(turn), 32'd0);
  endtask

  initial begin
    int selSeen, busySeen, svSeen;
    gif.hist_full = 1'b0;
    mcur = 0; mturn = 0;
    for (int i = 0; i < 4; i++) begin mg[i] = 0; msec[i] = 0; end

    // Reset state, then buttons in IDLE must have no effect
    doReset();
    checkResetValues();
    applyStimulus(BU);
    applyStimulus(BR);
    checkOutput("idle_guess0", 32'(gif.guess0), 32'd0);
    checkOutput("idle_cursor", 32'(cursor), 32'd0);
    applyStimulus(BS);
    checkOutput("idle_hist_select", 32'(gif.hist_select), 32'd0);
    applyStimulus(BM);
    checkOutput("idle_hist_mode", 32'(gif.hist_mode), 32'd0);

    // EDIT basics: cursor wrap, digit wrap, up beats left
    loadSecret(3, 1, 4, 1);
    applyStimulus(BL);
    mcur = 3;
    checkOutput("cursor_wrap_left", 32'(cursor), 32'd3);
    applyStimulus(BD);
    mg[3] = 7;
    checkOutput("digit_wrap_down", 32'(gif.guess3), 32'd7);
    applyStimulus(BU | BL);
    mg[3] = 0;
    checkOutput("up_left_digit", 32'(gif.guess3), 32'd0);
    checkOutput("up_left_cursor", 32'(cursor), 32'd3);

    // First scored guess 1-1-3-4 vs 3-1-4-1
    setGuess(1, 1, 3, 4);
    submitGuess(1'b0);
    checkOutput("edit_again_busy", 32'(busy), 32'd0);

    // Review from EDIT
    applyStimulus(BM);
    checkOutput("review_mode", 32'(gif.hist_mode), 32'd1);
    applyStimulus(BU);
    checkOutput("review_up_pulse", 32'(gif.hist_up), 32'd1);
    checkOutput("review_guess_frozen", 32'(gif.guess3), 32'(mg[3]));
    @(posedge clk); #1;
    checkOutput("review_up_end", 32'(gif.hist_up), 32'd0);
    applyStimulus(BD);
    checkOutput("review_down_pulse", {30'd0, gif.hist_down, gif.hist_up}, 32'd2);
    applyStimulus(BS);
    checkOutput("review_no_select", 32'(gif.hist_select), 32'd0);
    applyStimulus(BM);
    checkOutput("review_exit", 32'(gif.hist_mode), 32'd0);

    // Duplicate digits
    setGuess(2, 2, 5, 6);
`ifdef GAME_CTRL_DUP_CHECK_EN
    applyStimulus(BS);
    checkOutput("dup_reject", 32'(reject), 32'd1);
    checkOutput("dup_no_select", 32'(gif.hist_select), 32'd0);
    @(posedge clk); #1;
    checkOutput("dup_reject_end", 32'(reject), 32'd0);
    checkOutput("dup_not_busy", 32'(busy), 32'd0);
    checkOutput("dup_turn", 32'(turn), 32'(mturn));
`else
    submitGuess(1'b0);
    checkOutput("dup_reject_tied", 32'(reject), 32'd0);
`endif

    // Winning guess, then post-win behaviour
    setGuess(3, 1, 4, 1);
    submitGuess(1'b0);
    applyStimulus(BS);
    checkOutput("won_no_select", 32'(gif.hist_select), 32'd0);
    checkOutput("won_not_busy", 32'(busy), 32'd0);
    applyStimulus(BM);
    checkOutput("won_review_mode", 32'(gif.hist_mode), 32'd1);
    applyStimulus(BU);
    checkOutput("won_review_up", 32'(gif.hist_up), 32'd1);
    @(posedge clk); #1;
    checkOutput("won_review_up_end", 32'(gif.hist_up), 32'd0);
    checkOutput("won_held", 32'(won), 32'd1);

    // Loss after MAX_TURNS wrong guesses
    doReset();
    loadSecret(5, 6, 7, 0);
    setGuess(1, 2, 3, 5);
    for (int t = 0; t < MAX_TURNS; t++) submitGuess(1'b0);
    applyStimulus(BU);
    checkOutput("lost_frozen_guess0", 32'(gif.guess0), 32'd1);

    // Loss from a full history on turn 3
    doReset();
    loadSecret(1, 2, 3, 4);
    submitGuess(1'b0);
    submitGuess(1'b0);
    submitGuess(1'b1);
    checkOutput("hist_full_turn", 32'(turn), 32'd3);

    // Reset in the middle of a scoring pass
    doReset();
    loadSecret(2, 2, 2, 2);
    applyStimulus(BS);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_score_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkResetValues();
    @(posedge clk); #1 reset = 1'b0;
    selSeen = 0; busySeen = 0; svSeen = 0;
    for (int c = 0; c < 12; c++) begin
      if (gif.hist_select) selSeen++;
      if (busy) busySeen++;
      if (score_valid) svSeen++;
      @(posedge clk); #1;
    end
    checkOutput("post_rst_hist_select", 32'(selSeen), 32'd0);
    checkOutput("post_rst_busy", 32'(busySeen), 32'd0);
    checkOutput("post_rst_score_valid", 32'(svSeen), 32'd0);
    applyStimulus(BU);
    checkOutput("post_rst_idle", 32'(gif.guess0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level turn sequencer for the code-breaking game. Owns the working guess and cursor, and latches the secret code. Drives the history block's mode/up/down/select inputs and computes black/white peg scores over a multi-cycle scoring pass. Decides win/loss, and sits between the button debouncers, the secret-code generator and the history block.

Parameters:
MAX_TURNS, 8, number of scored turns before loss
TURN_W, 4, width of turn counter (must hold MAX_TURNS)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_left, btn_right, btn_up, btn_down, btn_select, btn_mode  input  1 each  debounced single-cycle button pulses
secret0..secret3  input  3 each  secret code digits from generator
secret_valid  input  1  secret digits valid this cycle
hist_full  input  1  history block has no free turn slot
guess0..guess3  output  3 each  working guess, to history guess0..3
cursor  output  2  digit currently being edited
hist_mode  output  1  to history mode (1 = review)
hist_up, hist_down, hist_select  output  1 each  single-cycle pulses to history btn_up/btn_down/btn_select
black, white  output  3 each  score of last committed guess
score_valid  output  1  black/white hold a valid score
turn  output  TURN_W  number of scored turns
busy  output  1  high while in SCORE
won, lost  output  1 each  terminal status
reject  output  1  single-cycle pulse, guess refused (see Optional Feature)

Behaviour:
- All outputs registered. Reset values: guess*=0, cursor=0, hist_*=0, black=white=0, score_valid=0, turn=0, busy=0, won=lost=0, reject=0; state=IDLE; secret regs=0.
- Reset asserted at any point, including mid-SCORE, returns every register to its reset value immediately. No pending hist_select survives reset.
- States: IDLE, EDIT, SCORE, REVIEW, WON, LOST.
- IDLE: all buttons ignored. On a cycle with secret_valid=1, latch secret0..3 and go to EDIT. secret_valid is ignored in every other state.
- EDIT: one action per cycle, priority select > mode > up/down > left/right.
  - left/right: cursor -1/+1 mod 4 (0 -> 3 and 3 -> 0 wrap).
  - up/down: guess[cursor] +1/-1 mod 8 (7 -> 0 and 0 -> 7).
  - select at cycle N: hist_select=1 during cycle N+1 only, guess unchanged. Go to SCORE at N+1.
  - mode: go to REVIEW with hist_mode=1 from the next cycle.
- SCORE: busy=1, all buttons ignored, occupies exactly 8 cycles (N+1..N+8).
  - First cycle: compute black = count of positions with guess[i]==secret[i].
  - Cycle k, k=0..7: acc += min(count of digit k in guess, count of digit k in secret).
  - At the edge ending N+8, black and white=acc-black are loaded, score_valid=1 (level, held until the next SCORE entry clears it), and turn+=1; busy drops.
  - Next state:
    - black==4 -> WON.
    - else turn(new)==MAX_TURNS or hist_full==1 -> LOST.
    - else EDIT, with cursor kept and guess kept.
- REVIEW: hist_mode=1. btn_up/btn_down produce a hist_up/hist_down pulse on the following cycle; guess and cursor are frozen. btn_mode returns to the prior state (EDIT/WON/LOST) with hist_mode=0. select, left and right are ignored.
- WON/LOST: won or lost held at 1 until reset. Only btn_mode (enters REVIEW) has an effect.
- hist_up, hist_down and hist_select are never high in the same cycle, and each is high for exactly one cycle per triggering button.

Optional Feature:
GAME_CTRL_DUP_CHECK_EN:
- Defined: select in EDIT with any two guess digits equal is refused. No hist_select, state stays EDIT, reject=1 for one cycle. Scoring is unaffected for accepted guesses.
- Undefined: duplicates are accepted and reject is tied to 0.

Test Plan:
- Reset, secret_valid with secret=3-1-4-1 -> EDIT next cycle; buttons pressed while in IDLE beforehand have no effect on guess/cursor.
- In EDIT, btn_left from cursor 0 -> cursor 3; btn_down on digit value 0 -> 7; btn_up and btn_left together -> only the digit changes.
- Guess 1-1-3-4 vs secret 3-1-4-1, select at cycle N -> hist_select high only at N+1, busy N+1..N+8, black=1, white=3, score_valid=1 at N+9, turn=1, back to EDIT.
- Guess equal to secret -> black=4, white=0, won=1 held; btn_select afterwards gives no hist_select; btn_mode -> hist_mode=1, btn_up -> one hist_up pulse.
- MAX_TURNS=8, eight wrong guesses -> lost=1 after the 8th score; separately, hist_full=1 on turn 3 -> lost=1 with turn=3; reset asserted mid-SCORE -> all outputs return to reset values and no hist_select is issued.
- With GAME_CTRL_DUP_CHECK_EN, guess 2-2-5-6 select -> reject pulse, no hist_select, turn unchanged; without the macro -> scored normally.
